// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed seven-segment scanner with frame-synchronous display update.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module seven_seg_scanner #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] thousands,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       load,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frame_done
);

    localparam int unsigned CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] TC = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {SLOT0, SLOT1, SLOT2, SLOT3} slot_t;

    slot_t         slot, slot_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          at_tc;
    logic          wrap;
    logic [15:0]   pending;
    logic [15:0]   display;
    logic          pend_valid;
    logic [15:0]   digits_in;
    logic [3:0]    digit;
    logic [3:0]    an_nxt;
    logic [6:0]    seg_code;
    logic [6:0]    seg_nxt;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    assign digits_in = {thousands, hundreds, tens, ones};

    always_comb begin
        at_tc    = (cnt == TC);
        cnt_nxt  = at_tc ? '0 : cnt + 1'b1;
        slot_nxt = slot;
        if (at_tc) begin
            case (slot)
                SLOT0:   slot_nxt = SLOT1;
                SLOT1:   slot_nxt = SLOT2;
                SLOT2:   slot_nxt = SLOT3;
                SLOT3:   slot_nxt = SLOT0;
                default: slot_nxt = SLOT0;
            endcase
        end
        wrap = at_tc && (slot == SLOT3);
    end

    // Anode and cathode are both derived from the current slot so they register on the same edge.
    always_comb begin
        an_nxt = 4'b1111;
        digit  = '0;
        case (slot)
            SLOT0:   begin an_nxt = 4'b1110; digit = display[3:0];   end
            SLOT1:   begin an_nxt = 4'b1101; digit = display[7:4];   end
            SLOT2:   begin an_nxt = 4'b1011; digit = display[11:8];  end
            SLOT3:   begin an_nxt = 4'b0111; digit = display[15:12]; end
            default: begin an_nxt = 4'b1111; digit = '0;             end
        endcase
        seg_code = decode(digit);
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic blank;

    // A digit is a leading zero when it and every more-significant digit are zero.
    always_comb begin
        blank = 1'b0;
        case (slot)
            SLOT1:   blank = (display[15:4] == '0);
            SLOT2:   blank = (display[15:8] == '0);
            SLOT3:   blank = (display[15:12] == '0);
            default: blank = 1'b0;
        endcase
        seg_nxt = blank ? '1 : seg_code;
    end
`else
    always_comb begin
        seg_nxt = seg_code;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            slot       <= SLOT0;
            pending    <= '0;
            pend_valid <= 1'b0;
            display    <= '0;
            an         <= '1;
            seg        <= '1;
            frame_done <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            slot       <= slot_nxt;
            an         <= an_nxt;
            seg        <= seg_nxt;
            frame_done <= wrap;
            if (load) begin
                pending <= digits_in;
            end
            // A load on the boundary edge bypasses pending straight into the display.
            if (wrap) begin
                if (load) begin
                    display <= digits_in;
                end else if (pend_valid) begin
                    display <= pending;
                end
                pend_valid <= 1'b0;
            end else if (load) begin
                pend_valid <= 1'b1;
            end
        end
    end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter: REFRESH_DIV, default 50000, clock cycles each digit is driven (legal range 2..2^20).
REQ-002 Port: clk  input  1  system clock; all state on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: thousands  input  4  BCD digit 3 (most significant).
REQ-005 Port: hundreds  input  4  BCD digit 2.
REQ-006 Port: tens  input  4  BCD digit 1.
REQ-007 Port: ones  input  4  BCD digit 0 (least significant).
REQ-008 Port: load  input  1  one-cycle strobe; capture the four digit inputs.
REQ-009 Port: seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low, registered.
REQ-010 Port: an  output  4  anodes, active-low, one-hot-low, an[k] = digit k, registered.
REQ-011 Port: frame_done  output  1  one-cycle pulse when digit 3 slot ends.

Function
REQ-012 The block SHALL hold a pending register (16 bits) and a display register (16 bits).
REQ-013 On load=1, pending SHALL capture {thousands,hundreds,tens,ones} at that edge and set a pending-valid flag.
REQ-014 The display register SHALL update from pending only at a frame boundary (slot 3 -> slot 0 transition), then clear pending-valid; no tearing mid-frame.
REQ-015 load coincident with a frame boundary: the newly strobed values SHALL be transferred at that same boundary (load-to-display bypass); later loads overwrite pending (last-wins).
REQ-016 A slot counter SHALL count 0..REFRESH_DIV-1; at terminal count it wraps to 0 and the digit index advances 0->1->2->3->0.
REQ-017 an SHALL drive low only bit [index]; seg SHALL show the display digit at index; both change on the same edge (no ghosting skew).
REQ-018 Decode (active-low, gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-019 Digit codes 10..15 (invalid BCD) SHALL display a dash: seg=0111111.
REQ-020 frame_done SHALL pulse high for exactly the cycle in which index wraps 3->0 (the same edge the display register updates).
REQ-021 Scan period SHALL be exactly 4*REFRESH_DIV cycles; no idle/blank slot.

Reset
REQ-022 While rst=1: an=1111, seg=1111111, frame_done=0, counter=0, index=0, pending=display=0, pending-valid=0.
REQ-023 First clock after rst deassertion SHALL set an=1110 showing display digit 0 (i.e. "0").
REQ-024 rst asserted mid-frame or mid-load SHALL discard pending data; a load on the first active edge after release SHALL be accepted.

Configuration
REQ-025 Macro LEADING_ZERO_BLANK_EN: when defined, digits 3,2,1 SHALL show all-off (seg=1111111, anode still cycles) while they and every more-significant digit equal 0; digit 0 is never blanked.
REQ-026 Without LEADING_ZERO_BLANK_EN, all four digits SHALL always be decoded per REQ-018/REQ-019.

Verification
REQ-027 Reset release, REFRESH_DIV=4 -> an sequence 1110,1101,1011,0111 each held 4 cycles, seg=1000000 throughout, frame_done every 16 cycles.
REQ-028 load 1,2,3,4 (th,hu,te,on) mid-slot 1 -> display unchanged until wrap; next frame digit0 seg=0011001, digit3 seg=1111001.
REQ-029 Two loads in one frame (1234 then 5678) -> next frame shows 5678 only; 1234 never appears.
REQ-030 load 0,0,4,2 with LEADING_ZERO_BLANK_EN -> slots 3,2 seg=1111111, slot1=0011001, slot0=0100100; without macro slots 3,2 seg=1000000.
REQ-031 ones=4'hC loaded -> slot 0 seg=0111111; rst pulsed mid-slot 2 -> outputs go all-off asynchronously, restart at slot 0 showing "0".
